ign_scheduler: RTL and testbench
================================

IGN_SCHEDULER -- requirements
Module: ign_scheduler

Interface
REQ-001 SHALL have parameter N_CYL, default 4, number of cylinders/coil outputs.
REQ-002 SHALL have parameter N_TMR, default 2, number of shared delay timers.
REQ-003 SHALL have parameter MARGIN, default 20, window slack in phase quanta.
REQ-004 SHALL have parameter COMP, default 4, delay latency compensation in clocks.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port tooth  input  1  one-cycle tooth-event pulse.
REQ-008 SHALL have port eng_phase  input  16  engine phase at tooth.
REQ-009 SHALL have port next_tooth_width  input  16  quanta to next tooth.
REQ-010 SHALL have port tooth_period  input  32  clocks per tooth.
REQ-011 SHALL have port cyl_timing  input  16*N_CYL  per-cylinder spark angle, cylinder i at bits [16i+15:16i].
REQ-012 SHALL have port cyl_enable  input  N_CYL  per-cylinder enable.
REQ-013 SHALL have port coil_fire  output  N_CYL  one-cycle fire pulse per cylinder.
REQ-014 SHALL have port busy  output  1  high while scanning.
REQ-015 SHALL have port overrun  output  1  sticky: event dropped, no free timer.
REQ-016 SHALL have port drop_cnt  output  8  saturating dropped-event count.
REQ-017 SHALL have port tooth_miss  output  1  one-cycle pulse: tooth ignored while busy.

Function
REQ-018 SHALL implement FSM states IDLE, SCAN; IDLE->SCAN on tooth; SCAN->IDLE after cylinder N_CYL-1 is evaluated.
REQ-019 On the tooth-sampling edge, SHALL snapshot eng_phase, next_tooth_width, tooth_period, cyl_timing, cyl_enable and set index 0.
REQ-020 In SCAN, SHALL evaluate exactly one cylinder per cycle, index ascending, using snapshot values only.
REQ-021 SHALL compute q = cyl_timing[i] - eng_phase, modulo 2^16.
REQ-022 Cylinder is in-window iff enabled, q != 0, and q <= next_tooth_width + MARGIN (17-bit compare, no wrap).
REQ-023 Cylinder with a timer already armed for it SHALL be skipped (no double arm, not counted as drop).
REQ-024 In-window cylinder SHALL be allocated the lowest-index free timer on the evaluation edge.
REQ-025 Delay D = ((tooth_period * q) >> 8) - COMP, 48-bit product, result truncated to 32 bits, saturated to 0 when the shift result < COMP.
REQ-026 Armed timer SHALL assert coil_fire[cyl] for exactly one cycle, D+1 cycles after its load edge, then free itself on that same edge.
REQ-027 A timer freed on edge N SHALL be allocatable at the evaluation edge N+1 or later, not at N.
REQ-028 No free timer for an in-window cylinder: SHALL set overrun and increment drop_cnt, saturating at 255.
REQ-029 tooth while in SCAN SHALL be ignored for scheduling and pulse tooth_miss one cycle.
REQ-030 Timers SHALL run independently of FSM state; a new tooth SHALL NOT cancel armed timers.
REQ-031 Multiple timers firing on the same edge SHALL assert all corresponding coil_fire bits together.
REQ-032 busy SHALL equal (state == SCAN).

Reset
REQ-033 reset_n low SHALL asynchronously clear FSM to IDLE and clear all timers, snapshots, coil_fire, busy, overrun, drop_cnt, tooth_miss to 0.
REQ-034 Reset during an armed timer SHALL produce no fire pulse, including after reset release.
REQ-035 overrun and drop_cnt SHALL be cleared only by reset.

Structure
REQ-036 Shared package ign_pkg SHALL hold defaults for N_CYL, N_TMR, MARGIN, COMP, and the FSM state encoding.
REQ-037 The timer SHALL be sub-module ign_delay_tmr (load, delay, cyl tag, fire, busy), instantiated N_TMR times.
REQ-038 The delay multiplier SHALL be shared by all cylinders: one instance, used in SCAN.

Verification
REQ-039 period=256, eng_phase=100, cyl0 timing=110, width=30, only cyl0 enabled, tooth sampled edge E -> coil_fire[0] single pulse after edge E+8 (D=6).
REQ-040 All 4 in-window with N_TMR=2 -> cyl0/cyl1 fire, cyl2/cyl3 dropped, overrun=1, drop_cnt=2.
REQ-041 q=51 with width=30 (limit 50) -> no fire; q=50 -> fire; timing==eng_phase -> no fire.
REQ-042 eng_phase=65530, timing=4 (q=10 via wrap), period=256 -> fires, D=6.
REQ-043 tooth pulsed again 2 cycles after first -> tooth_miss one cycle, no extra scan; armed cylinder fires once only.
REQ-044 Assert reset_n low 2 cycles after arming D=100 -> outputs 0 immediately, no coil_fire for 200 cycles after release.

Source files
------------

// File: rtl/ign_pkg.sv
// Shared defaults and FSM encoding for the ignition scheduler.
package ign_pkg;

  localparam int N_CYL_DEF  = 4;
  localparam int N_TMR_DEF  = 2;
  localparam int MARGIN_DEF = 20;
  localparam int COMP_DEF   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // Width of an index able to address n items (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ign_delay_tmr.sv
// One-shot delay timer: loaded with a count and a cylinder tag, it pulses
// fire for one cycle delay+1 cycles after the load edge and releases itself
// on that same edge.
module ign_delay_tmr #(
  parameter int CYL_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [31:0]      delay,
  input  logic [CYL_W-1:0] cyl_in,
  output logic             fire,
  output logic             busy,
  output logic [CYL_W-1:0] cyl
);

  logic [31:0]      cnt_q,  cnt_d;
  logic             busy_q, busy_d;
  logic             fire_q, fire_d;
  logic [CYL_W-1:0] cyl_q,  cyl_d;

  // Countdown: load arms the timer, terminal count fires and frees it.
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    fire_d = 1'b0;
    cyl_d  = cyl_q;
    if (load) begin
      cnt_d  = delay;
      busy_d = 1'b1;
      cyl_d  = cyl_in;
    end else if (busy_q) begin
      if (cnt_q == 32'd0) begin
        fire_d = 1'b1;
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 32'd1;
      end
    end
  end

  // State register; reset drops any armed delay without firing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= 32'd0;
      busy_q <= 1'b0;
      fire_q <= 1'b0;
      cyl_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      fire_q <= fire_d;
      cyl_q  <= cyl_d;
    end
  end

  assign fire = fire_q;
  assign busy = busy_q;
  assign cyl  = cyl_q;

endmodule

// File: rtl/ign_scheduler.sv
// Ignition scheduler: on each accepted tooth, snapshots the engine state and
// scans the cylinders one per cycle, arming a shared delay timer for every
// cylinder whose spark angle falls inside the next tooth window.
module ign_scheduler
  import ign_pkg::*;
#(
  parameter int N_CYL  = N_CYL_DEF,
  parameter int N_TMR  = N_TMR_DEF,
  parameter int MARGIN = MARGIN_DEF,
  parameter int COMP   = COMP_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tooth,
  input  logic [15:0]         eng_phase,
  input  logic [15:0]         next_tooth_width,
  input  logic [31:0]         tooth_period,
  input  logic [16*N_CYL-1:0] cyl_timing,
  input  logic [N_CYL-1:0]    cyl_enable,
  output logic [N_CYL-1:0]    coil_fire,
  output logic                busy,
  output logic                overrun,
  output logic [7:0]          drop_cnt,
  output logic                tooth_miss
);

  localparam int CYL_W = idx_width(N_CYL);
  localparam logic [CYL_W-1:0] LAST_IDX = CYL_W'(N_CYL - 1);

  // FSM, scan index and snapshot registers
  state_e              state_q,   state_d;
  logic [CYL_W-1:0]    idx_q,     idx_d;
  logic [15:0]         phase_q,   phase_d;
  logic [15:0]         width_q,   width_d;
  logic [31:0]         period_q,  period_d;
  logic [16*N_CYL-1:0] timing_q,  timing_d;
  logic [N_CYL-1:0]    enable_q,  enable_d;
  logic                overrun_q, overrun_d;
  logic [7:0]          drop_q,    drop_d;
  logic                miss_q,    miss_d;

  // Evaluation of the cylinder currently addressed by idx_q
  logic [15:0] cur_timing;
  logic        cur_en;
  logic [15:0] q_off;
  logic [16:0] win_limit;
  logic        in_win;
  logic [47:0] prod;
  logic [39:0] prod_sh;
  logic [31:0] delay_val;
  logic        unused_prod_lo;
  logic        scan_eval;
  logic        armed_hit;
  logic        want_arm;
  logic        free_found;
  logic        do_drop;

  // Timer bank
  logic [N_TMR-1:0] tmr_load;
  logic [N_TMR-1:0] tmr_fire;
  logic [N_TMR-1:0] tmr_busy;
  logic [CYL_W-1:0] tmr_cyl [N_TMR];

  // Window test, single shared delay multiply and timer allocation.
  always_comb begin
    cur_timing = 16'd0;
    cur_en     = 1'b0;
    for (int c = 0; c < N_CYL; c++) begin
      if (idx_q == CYL_W'(c)) begin
        cur_timing = timing_q[16*c +: 16];
        cur_en     = enable_q[c];
      end
    end

    // Phase distance to the spark angle, wrapping around the 16-bit cycle.
    q_off     = cur_timing - phase_q;
    win_limit = {1'b0, width_q} + 17'(MARGIN);
    in_win    = cur_en && (q_off != 16'd0) && ({1'b0, q_off} <= win_limit);

    // Quanta to clocks; the fixed pipeline latency is taken off, floored at 0.
    prod           = 48'(period_q) * 48'(q_off);
    prod_sh        = prod[47:8];
    unused_prod_lo = ^prod[7:0];
    if (prod_sh < 40'(COMP)) begin
      delay_val = 32'd0;
    end else begin
      delay_val = prod_sh[31:0] - 32'(COMP);
    end

    scan_eval = (state_q == SCAN);

    // A cylinder that still owns a running timer is left alone.
    armed_hit = 1'b0;
    for (int t = 0; t < N_TMR; t++) begin
      if (tmr_busy[t] && (tmr_cyl[t] == idx_q)) begin
        armed_hit = 1'b1;
      end
    end

    want_arm   = scan_eval && in_win && !armed_hit;
    tmr_load   = '0;
    free_found = 1'b0;
    for (int t = 0; t < N_TMR; t++) begin
      if (want_arm && !free_found && !tmr_busy[t]) begin
        tmr_load[t] = 1'b1;
        free_found  = 1'b1;
      end
    end
    do_drop = want_arm && !free_found;
  end

  // Next-state logic: tooth acceptance, scan stepping, miss and drop bookkeeping.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    phase_d   = phase_q;
    width_d   = width_q;
    period_d  = period_q;
    timing_d  = timing_q;
    enable_d  = enable_q;
    miss_d    = 1'b0;
    overrun_d = overrun_q;
    drop_d    = drop_q;

    case (state_q)
      IDLE: begin
        if (tooth) begin
          phase_d  = eng_phase;
          width_d  = next_tooth_width;
          period_d = tooth_period;
          timing_d = cyl_timing;
          enable_d = cyl_enable;
          idx_d    = '0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        // A tooth arriving mid-scan is only reported, never scheduled.
        if (tooth) begin
          miss_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + CYL_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_drop) begin
      overrun_d = 1'b1;
      if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  // Control and snapshot registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      phase_q   <= 16'd0;
      width_q   <= 16'd0;
      period_q  <= 32'd0;
      timing_q  <= '0;
      enable_q  <= '0;
      overrun_q <= 1'b0;
      drop_q    <= 8'd0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      phase_q   <= phase_d;
      width_q   <= width_d;
      period_q  <= period_d;
      timing_q  <= timing_d;
      enable_q  <= enable_d;
      overrun_q <= overrun_d;
      drop_q    <= drop_d;
      miss_q    <= miss_d;
    end
  end

  // Timer bank; timers keep running regardless of the scan FSM.
  generate
    for (genvar gi = 0; gi < N_TMR; gi++) begin : g_tmr
      ign_delay_tmr #(
        .CYL_W (CYL_W)
      ) u_tmr (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (tmr_load[gi]),
        .delay   (delay_val),
        .cyl_in  (idx_q),
        .fire    (tmr_fire[gi]),
        .busy    (tmr_busy[gi]),
        .cyl     (tmr_cyl[gi])
      );
    end
  endgenerate

  // Route each firing timer to its cylinder's coil; simultaneous fires merge.
  always_comb begin
    coil_fire = '0;
    for (int t = 0; t < N_TMR; t++) begin
      for (int c = 0; c < N_CYL; c++) begin
        if (tmr_fire[t] && (tmr_cyl[t] == CYL_W'(c))) begin
          coil_fire[c] = 1'b1;
        end
      end
    end
  end

  assign busy       = (state_q == SCAN);
  assign overrun    = overrun_q;
  assign drop_cnt   = drop_q;
  assign tooth_miss = miss_q;

endmodule

// File: tb/tb_ign_scheduler.sv
// Bench for ign_scheduler: directed scenarios then randomized teeth, all
// checked every cycle against an event-time reference model.
module tb_ign_scheduler;

  localparam int NC   = 4;
  localparam int NT   = 2;
  localparam int MG   = 20;
  localparam int CP   = 4;
  localparam int MAXC = 16384;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            tooth = 1'b0;
  logic [15:0]     eng_phase = 16'd0;
  logic [15:0]     next_tooth_width = 16'd0;
  logic [31:0]     tooth_period = 32'd0;
  logic [16*NC-1:0] cyl_timing = '0;
  logic [NC-1:0]   cyl_enable = '0;
  logic [NC-1:0]   coil_fire;
  logic            busy;
  logic            overrun;
  logic [7:0]      drop_cnt;
  logic            tooth_miss;

  ign_scheduler #(
    .N_CYL  (NC),
    .N_TMR  (NT),
    .MARGIN (MG),
    .COMP   (CP)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .tooth            (tooth),
    .eng_phase        (eng_phase),
    .next_tooth_width (next_tooth_width),
    .tooth_period     (tooth_period),
    .cyl_timing       (cyl_timing),
    .cyl_enable       (cyl_enable),
    .coil_fire        (coil_fire),
    .busy             (busy),
    .overrun          (overrun),
    .drop_cnt         (drop_cnt),
    .tooth_miss       (tooth_miss)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit in_reset = 1'b0;

  // Reference model: expected outputs indexed by the edge after which they appear.
  logic [NC-1:0] exp_fire [MAXC];
  int            drops_at [MAXC];
  bit            miss_at  [MAXC];
  int            scan_start;
  int            scan_end;
  longint        tmr_free [NT];
  int            tmr_cyl  [NT];
  int            m_drop;
  bit            m_over;

  int fire_cnt [NC];
  int first_fire [NC];
  int miss_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < MAXC; k++) begin
      exp_fire[k] = '0;
      drops_at[k] = 0;
      miss_at[k]  = 1'b0;
    end
    for (int t = 0; t < NT; t++) begin
      tmr_free[t] = -1;
      tmr_cyl[t]  = -1;
    end
    scan_start = -100;
    scan_end   = -100;
    m_drop     = 0;
    m_over     = 1'b0;
  endtask

  task automatic clr_track();
    for (int i = 0; i < NC; i++) begin
      fire_cnt[i]   = 0;
      first_fire[i] = -1;
    end
    miss_cnt = 0;
  endtask

  // Predict the effect of a tooth sampled at edge e from the current inputs.
  task automatic model_edge(input int e);
    logic [15:0]     tq;
    logic [15:0]     qv;
    longint unsigned q;
    longint unsigned pr;
    longint unsigned sh;
    longint          d;
    longint          v;
    bit              inwin;
    bit              armed;
    int              found;
    if (in_reset || !tooth) return;
    if (e <= scan_end) begin
      miss_at[e] = 1'b1;
      $display("tooth cyc=%0d ignored (scan in progress)", e);
      return;
    end
    scan_start = e;
    scan_end   = e + NC;
    $display("tooth cyc=%0d phase=%0d width=%0d period=%0d en=%b", e, eng_phase,
             next_tooth_width, tooth_period, cyl_enable);
    pr = tooth_period;
    for (int i = 0; i < NC; i++) begin
      v     = e + 1 + i;
      tq    = cyl_timing[16*i +: 16];
      qv    = tq - eng_phase;
      q     = qv;
      inwin = cyl_enable[i] && (q != 0) && (q <= longint'(next_tooth_width) + MG);
      if (!inwin) continue;
      armed = 1'b0;
      for (int t = 0; t < NT; t++)
        if (tmr_free[t] >= v && tmr_cyl[t] == i) armed = 1'b1;
      if (armed) continue;
      found = -1;
      for (int t = 0; t < NT; t++)
        if (found < 0 && tmr_free[t] < v) found = t;
      if (found >= 0) begin
        sh = (pr * q) >> 8;
        d  = (sh < CP) ? 0 : longint'(sh - CP);
        tmr_free[found] = v + d + 1;
        tmr_cyl[found]  = i;
        if (v + d + 1 < MAXC) exp_fire[v + d + 1][i] = 1'b1;
      end else begin
        drops_at[v]++;
      end
    end
  endtask

  // Advance one clock and compare every output with the model.
  task automatic step();
    model_edge(cyc + 1);
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exceeded");
    end
    if (!in_reset && drops_at[cyc] > 0) begin
      m_drop += drops_at[cyc];
      if (m_drop > 255) m_drop = 255;
      m_over = 1'b1;
    end
    chk("coil_fire", coil_fire, exp_fire[cyc]);
    chk("busy", busy, (cyc >= scan_start && cyc <= scan_end - 1));
    chk("tooth_miss", tooth_miss, miss_at[cyc]);
    chk("overrun", overrun, m_over);
    chk("drop_cnt", drop_cnt, m_drop);
    for (int i = 0; i < NC; i++) begin
      if (coil_fire[i] === 1'b1) begin
        fire_cnt[i]++;
        if (first_fire[i] < 0) first_fire[i] = cyc;
      end
    end
    if (tooth_miss === 1'b1) miss_cnt++;
  endtask

  // Quiet cycles with scrambled inputs: only snapshot values may matter.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      eng_phase        = 16'($urandom);
      next_tooth_width = 16'($urandom);
      tooth_period     = $urandom;
      cyl_timing       = {$urandom, $urandom};
      cyl_enable       = 4'($urandom);
      step();
    end
  endtask

  task automatic set_inputs(input int ph, input int wd, input int per,
                            input int t0, input int t1, input int t2, input int t3,
                            input logic [NC-1:0] en);
    eng_phase        = 16'(ph);
    next_tooth_width = 16'(wd);
    tooth_period     = 32'(per);
    cyl_timing       = {16'(t3), 16'(t2), 16'(t1), 16'(t0)};
    cyl_enable       = en;
  endtask

  task automatic pulse_tooth(output int e);
    tooth = 1'b1;
    step();
    tooth = 1'b0;
    e = cyc;
  endtask

  task automatic apply_reset(input int hold);
    reset_n  = 1'b0;
    in_reset = 1'b1;
    #1;
    model_clear();
    chk("rst_coil_fire", coil_fire, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_tooth_miss", tooth_miss, 0);
    for (int k = 0; k < hold; k++) step();
    reset_n  = 1'b1;
    in_reset = 1'b0;
  endtask

  task automatic rand_tooth_inputs();
    int lim;
    tooth_period     = 32'($urandom_range(700, 16));
    next_tooth_width = 16'($urandom_range(80, 0));
    eng_phase        = 16'($urandom);
    lim              = int'(next_tooth_width) + MG + 3;
    for (int i = 0; i < NC; i++) begin
      if ($urandom_range(9, 0) < 7)
        cyl_timing[16*i +: 16] = eng_phase + 16'($urandom_range(lim, 0));
      else
        cyl_timing[16*i +: 16] = 16'($urandom);
    end
    cyl_enable = ($urandom_range(3, 0) != 0) ? 4'hF : 4'($urandom);
  endtask

  initial begin
    int e;
    model_clear();
    clr_track();
    #1;
    apply_reset(3);

    // Basic arm: q=10, period 256 -> D=6, fire after edge E+8.
    clr_track();
    set_inputs(100, 30, 256, 110, 0, 0, 0, 4'b0001);
    pulse_tooth(e);
    idle(12);
    chk("d1_fire_edge", first_fire[0], e + 8);
    chk("d1_fire_count", fire_cnt[0], 1);

    // All four in window with two timers: two fire, two dropped.
    clr_track();
    set_inputs(100, 30, 256, 110, 110, 110, 110, 4'b1111);
    pulse_tooth(e);
    idle(12);
    chk("d2_fire_c0", fire_cnt[0], 1);
    chk("d2_fire_c1", fire_cnt[1], 1);
    chk("d2_fire_c2", fire_cnt[2], 0);
    chk("d2_fire_c3", fire_cnt[3], 0);
    chk("d2_overrun", overrun, 1);
    chk("d2_drop_cnt", drop_cnt, 2);

    // Window edges: q=51 out, q=50 in (D=46), q=0 out, disabled cylinder out.
    clr_track();
    set_inputs(100, 30, 256, 151, 150, 100, 110, 4'b0111);
    pulse_tooth(e);
    idle(55);
    chk("d3_q51", fire_cnt[0], 0);
    chk("d3_q50", fire_cnt[1], 1);
    chk("d3_q50_edge", first_fire[1], e + 49);
    chk("d3_q0", fire_cnt[2], 0);
    chk("d3_disabled", fire_cnt[3], 0);

    // Phase wrap: 4 - 65530 = 10 mod 2^16.
    clr_track();
    set_inputs(65530, 30, 256, 4, 0, 0, 0, 4'b0001);
    pulse_tooth(e);
    idle(12);
    chk("d4_wrap_edge", first_fire[0], e + 8);

    // Second tooth two cycles in: reported as missed, single fire only.
    clr_track();
    set_inputs(100, 30, 256, 110, 0, 0, 0, 4'b0001);
    pulse_tooth(e);
    idle(1);
    tooth = 1'b1;
    step();
    tooth = 1'b0;
    idle(12);
    chk("d5_miss_count", miss_cnt, 1);
    chk("d5_fire_count", fire_cnt[0], 1);
    chk("d5_fire_edge", first_fire[0], e + 8);

    // Reset while a D=100 timer runs: outputs clear, and no late fire.
    clr_track();
    set_inputs(0, 90, 256, 104, 0, 0, 0, 4'b0001);
    pulse_tooth(e);
    idle(3);
    apply_reset(2);
    idle(200);
    chk("d6_no_fire", fire_cnt[0], 0);

    // Randomized teeth with random spacing and occasional resets.
    while (cyc < 12000) begin
      rand_tooth_inputs();
      tooth = 1'b1;
      step();
      tooth = 1'b0;
      if ($urandom_range(99, 0) == 0) apply_reset(2);
      idle($urandom_range(40, 0));
    end
    idle(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
